// File: rtl/gray_counter.sv
// gray_counter: up/down Gray-code counter with parallel Gray load.
// The count is held in binary; the registered output g is the Gray encoding
// of that binary value. Count ends either wrap modulo 2^WIDTH (WRAP=1) or
// saturate (WRAP=0). Each end-of-range event produces a one-cycle pulse on
// wrap or sat, registered on the same edge as g.
module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] g,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic [WIDTH-1:0] bin_step;
  logic             at_end;

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] gv);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = gv[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gv[i];
    end
    return b;
  endfunction

  // Next count in the requested direction and whether the current count
  // sits at the end of the range for that direction.
  always_comb begin
    bin_step = up ? (bin_q + ONE) : (bin_q - ONE);
    at_end   = up ? (bin_q == MAX) : (bin_q == ZERO);
  end

  // Next-state selection: load beats count; idle cycles hold and clear pulses.
  always_comb begin
    bin_d  = bin_q;
    g_d    = g_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (load) begin
      bin_d = gray_to_bin(load_g);
      g_d   = load_g;
    end else if (en) begin
      if (!WRAP && at_end) begin
        // Blocked step: count holds, pulse sat on every blocked cycle.
        sat_d = 1'b1;
      end else begin
        bin_d  = bin_step;
        g_d    = bin_step ^ (bin_step >> 1);
        wrap_d = WRAP & at_end;
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign g    = g_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: one wrapping and one saturating instance share
// stimulus. Directed steps first, then a randomized run against an integer
// reference count.
module tb_gray_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  // Clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         en = 1'b0, up = 1'b1, load = 1'b0;
  logic [W-1:0] load_g = '0;
  logic [W-1:0] g_w, g_s;
  logic         wrap_w, sat_w, wrap_s, sat_s;

  gray_counter #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_g(load_g),
    .g(g_w), .wrap(wrap_w), .sat(sat_w)
  );

  gray_counter #(.WIDTH(W), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_g(load_g),
    .g(g_s), .wrap(wrap_s), .sat(sat_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer counts and expected pulses.
  int m_w = 0, m_s = 0;
  bit e_wrap = 0, e_sat = 0;

  int gray_seq [0:16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  function automatic logic [W-1:0] to_gray(input int v);
    logic [W-1:0] b;
    b = v[W-1:0];
    return b ^ (b >> 1);
  endfunction

  // Downstream decoder: running XOR from the MSB.
  function automatic int decode(input logic [W-1:0] gv);
    int acc;
    int v;
    acc = 0;
    v = 0;
    for (int i = W - 1; i >= 0; i--) begin
      acc = acc ^ int'(gv[i]);
      v = v | (acc << i);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0;
    m_s = 0;
    e_wrap = 0;
    e_sat = 0;
  endtask

  // Advance the model by the rules for the inputs presented this cycle.
  task automatic model_apply();
    e_wrap = 0;
    e_sat  = 0;
    if (load) begin
      m_w = decode(load_g);
      m_s = m_w;
    end else if (en) begin
      if (up) begin
        e_wrap = (m_w == MOD - 1);
        m_w = (m_w + 1) % MOD;
        if (m_s == MOD - 1) e_sat = 1;
        else m_s = m_s + 1;
      end else begin
        e_wrap = (m_w == 0);
        m_w = (m_w + MOD - 1) % MOD;
        if (m_s == 0) e_sat = 1;
        else m_s = m_s - 1;
      end
    end
  endtask

  // Driver: commit model for current inputs, then sample 1ns after the edge.
  task automatic tick();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    chk("wrap_inst_g",    g_w,               to_gray(m_w));
    chk("wrap_inst_dec",  decode(g_w),       m_w);
    chk("wrap_inst_wrap", wrap_w,            e_wrap);
    chk("wrap_inst_sat",  sat_w,             1'b0);
    chk("sat_inst_g",     g_s,               to_gray(m_s));
    chk("sat_inst_dec",   decode(g_s),       m_s);
    chk("sat_inst_sat",   sat_s,             e_sat);
    chk("sat_inst_wrap",  wrap_s,            1'b0);
  endtask

  initial begin
    logic [W-1:0] prev_w, prev_s;
    bit stepped;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_g_w", g_w, 4'b0000);
    chk("reset_g_s", g_s, 4'b0000);
    chk("reset_wrap", wrap_w, 1'b0);
    chk("reset_sat", sat_s, 1'b0);
    rst = 1'b0;
    model_reset();

    // Full up cycle through all 16 codes
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("up_seq_%0d", i), g_w, gray_seq[i+1]);
      chk($sformatf("up_wrap_%0d", i), wrap_w, (i == 15));
      check_all();
    end

    // Down from 0 wraps to 1000, then 1001
    up = 1'b0;
    tick();
    chk("down_wrap_g", g_w, 4'b1000);
    chk("down_wrap_pulse", wrap_w, 1'b1);
    check_all();
    tick();
    chk("down_next_g", g_w, 4'b1001);
    chk("down_next_wrap", wrap_w, 1'b0);
    check_all();

    // Load wins over count
    load = 1'b1; load_g = 4'b0110; en = 1'b1; up = 1'b0;
    tick();
    chk("load_g_w", g_w, 4'b0110);
    chk("load_g_s", g_s, 4'b0110);
    check_all();
    load = 1'b0; up = 1'b1;
    tick();
    chk("after_load_up", g_w, 4'b0111);
    check_all();

    // Saturation at the top
    load = 1'b1; load_g = 4'b1000;
    tick();
    check_all();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_hold_g_%0d", i), g_s, 4'b1000);
      chk($sformatf("sat_pulse_%0d", i), sat_s, 1'b1);
      check_all();
    end
    up = 1'b0;
    tick();
    chk("sat_release_g", g_s, 4'b1001);
    chk("sat_release_pulse", sat_s, 1'b0);
    check_all();

    // Async reset mid-count
    load = 1'b1; load_g = 4'b1101;
    tick();
    chk("preload_1101", g_w, 4'b1101);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_g_w", g_w, 4'b0000);
    chk("async_rst_g_s", g_s, 4'b0000);
    chk("async_rst_wrap", wrap_w, 1'b0);
    chk("async_rst_sat", sat_s, 1'b0);
    en = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_hold_%0d", i), g_w, 4'b0000);
      check_all();
    end

    // Randomized run
    for (int c = 0; c < 10000; c++) begin
      en     = ($urandom_range(0, 3) != 0);
      up     = $urandom_range(0, 1) != 0;
      load   = ($urandom_range(0, 15) == 0);
      load_g = W'($urandom_range(0, MOD - 1));
      prev_w = g_w;
      prev_s = g_s;
      stepped = en && !load;
      tick();
      check_all();
      if (stepped) begin
        chk("rand_onebit_w", $countones(g_w ^ prev_w), 1);
        chk("rand_onebit_s", $countones(g_s ^ prev_s), e_sat ? 0 : 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
